// File: rtl/counter_share_if.sv
// Handshake bundle between two interval clients and the shared-counter controller.
// Requests and lengths flow client -> controller; grants, completions and count flow back.
interface counter_share_if #(
  parameter int unsigned W = 4
);
  logic         req0;
  logic [W-1:0] len0;
  logic         req1;
  logic [W-1:0] len1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic         busy;
  logic [W-1:0] count;

  modport master (
    output req0, len0, req1, len1,
    input  gnt0, gnt1, done0, done1, busy, count
  );

  modport slave (
    input  req0, len0, req1, len1,
    output gnt0, gnt1, done0, done1, busy, count
  );
endinterface

// File: rtl/counter_share_ctrl.sv
// Round-robin owner of one W-bit up counter shared by two requesters; the owner's
// interval runs count 0..len-1 and ends with a one-cycle done pulse to that owner.
module counter_share_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             reset,
  counter_share_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e       state_q;
  logic         owner_q;
  logic         last_q;
  logic [W-1:0] len_q;
  logic [W-1:0] count_q;
  logic         gnt0_q;
  logic         gnt1_q;
  logic         done0_q;
  logic         done1_q;
  logic         busy_q;

  logic         any_req_d;
  logic         win1_d;
  logic [W-1:0] len_sel_d;
  logic [W-1:0] len_d;
  logic         own_req_c;
  logic         terminal_c;

  // Arbitration: a lone requester wins; on a tie the one that did not own last wins.
  always_comb begin
    any_req_d  = bus.req0 | bus.req1;
    win1_d     = bus.req1 & (~bus.req0 | ~last_q);
    len_sel_d  = win1_d ? bus.len1 : bus.len0;
    len_d      = (len_sel_d == '0) ? W'(1) : len_sel_d;
    own_req_c  = owner_q ? bus.req1 : bus.req0;
    terminal_c = (count_q == (len_q - W'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= W'(1);
      count_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            state_q <= ST_RUN;
            owner_q <= win1_d;
            last_q  <= win1_d;
            len_q   <= len_d;
            count_q <= '0;
            busy_q  <= 1'b1;
            gnt0_q  <= ~win1_d;
            gnt1_q  <= win1_d;
          end
        end
        ST_RUN: begin
          // A dropped request aborts silently and wins over the terminal count.
          if (!own_req_c) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (terminal_c) begin
            state_q <= ST_DONE;
            count_q <= '0;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
          end else begin
            count_q <= count_q + W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Bench for counter_share_ctrl: directed scenarios then randomized clients, all
// outputs compared each cycle against an interval-position reference model.
module tb_counter_share_ctrl;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  counter_share_if #(.W(W)) bus ();

  counter_share_ctrl #(.W(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: who owns the counter, how far into the interval it is, its length.
  int m_owner = -1;
  int m_pos   = 0;
  int m_len   = 1;
  int m_last  = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int w;
    int l;
    if (reset) begin
      m_owner = -1;
      m_pos   = 0;
      m_len   = 1;
      m_last  = 1;
    end else if (m_owner < 0) begin
      w = -1;
      if (bus.req0 && bus.req1) w = 1 - m_last;
      else if (bus.req0)        w = 0;
      else if (bus.req1)        w = 1;
      if (w >= 0) begin
        l       = (w == 1) ? int'(bus.len1) : int'(bus.len0);
        m_owner = w;
        m_pos   = 0;
        m_len   = (l == 0) ? 1 : l;
        m_last  = w;
      end
    end else if (m_pos == m_len) begin
      m_owner = -1;
    end else if (!((m_owner == 1) ? bus.req1 : bus.req0)) begin
      m_owner = -1;
    end else begin
      m_pos++;
    end
  endtask

  function automatic logic e_gnt(input int r);
    return (m_owner == r) && (m_pos == 0);
  endfunction

  function automatic logic e_done(input int r);
    return (m_owner == r) && (m_pos == m_len);
  endfunction

  function automatic int e_count();
    return (m_owner >= 0 && m_pos < m_len) ? m_pos : 0;
  endfunction

  task automatic compare_all();
    check("gnt0",  32'(bus.gnt0),  32'(e_gnt(0)));
    check("gnt1",  32'(bus.gnt1),  32'(e_gnt(1)));
    check("done0", 32'(bus.done0), 32'(e_done(0)));
    check("done1", 32'(bus.done1), 32'(e_done(1)));
    check("busy",  32'(bus.busy),  32'(m_owner >= 0));
    check("count", 32'(bus.count), 32'(e_count()));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.gnt0;
      1:       return bus.gnt1;
      2:       return bus.done0;
      default: return bus.done1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    for (int k = 0; k < 40; k++) begin
      if (sig(sel)) break;
      step();
    end
    check(tag, 32'(sig(sel)), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int k = 0; k < cycles; k++) step();
    reset = 1'b0;
  endtask

  initial begin
    int gap;
    reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.len0 = '0;
    bus.len1 = '0;
    @(negedge clk);

    // Reset for two cycles.
    do_reset(2);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_count", 32'(bus.count), 32'd0);

    // Single requester, length 5.
    bus.req0 = 1'b1;
    bus.len0 = 4'd5;
    step();
    check("t2_gnt0", 32'(bus.gnt0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t2_count", 32'(bus.count), 32'(i));
      step();
    end
    check("t2_done0", 32'(bus.done0), 32'd1);
    check("t2_busy",  32'(bus.busy),  32'd1);
    bus.req0 = 1'b0;
    step();
    check("t2_idle", 32'(bus.busy), 32'd0);

    // Tie after reset: requester 0 first, then requester 1 after one idle cycle.
    do_reset(2);
    bus.req0 = 1'b1; bus.len0 = 4'd3;
    bus.req1 = 1'b1; bus.len1 = 4'd2;
    step();
    check("t3_gnt0_first", 32'(bus.gnt0), 32'd1);
    wait_for(2, "t3_done0");
    bus.req0 = 1'b0;
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      gap++;
      if (bus.gnt1) break;
    end
    check("t3_gap", 32'(gap), 32'd2);
    check("t3_cnt0", 32'(bus.count), 32'd0);
    step();
    check("t3_cnt1", 32'(bus.count), 32'd1);
    step();
    check("t3_done1", 32'(bus.done1), 32'd1);
    bus.req1 = 1'b0;
    step();

    // Zero length behaves as one tick.
    bus.req1 = 1'b1; bus.len1 = 4'd0;
    wait_for(1, "t4_gnt1");
    check("t4_cnt", 32'(bus.count), 32'd0);
    step();
    check("t4_done1", 32'(bus.done1), 32'd1);
    bus.req1 = 1'b0;
    step();
    step();

    // Abort: requester 1 drops at count 2.
    bus.req1 = 1'b1; bus.len1 = 4'd8;
    wait_for(1, "t5_gnt1");
    step();
    step();
    check("t5_cnt2", 32'(bus.count), 32'd2);
    bus.req1 = 1'b0;
    step();
    check("t5_busy", 32'(bus.busy),  32'd0);
    check("t5_done", 32'(bus.done1), 32'd0);
    check("t5_cnt",  32'(bus.count), 32'd0);
    step();

    // Reset in the middle of an interval, request still held.
    bus.req0 = 1'b1; bus.len0 = 4'd15;
    wait_for(0, "t6_gnt0");
    for (int k = 0; k < 3; k++) step();
    check("t6_cnt3", 32'(bus.count), 32'd3);
    do_reset(1);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    wait_for(0, "t6_regnt0");
    bus.req0 = 1'b0;
    step();
    step();

    // Randomized clients: raise, hold, sometimes abort, sometimes linger after done.
    for (int c = 0; c < 4000; c++) begin
      step();
      if (e_done(0) && ($urandom_range(3, 0) != 0)) bus.req0 = 1'b0;
      else if (!bus.req0 && ($urandom_range(3, 0) == 0)) begin
        bus.req0 = 1'b1;
        bus.len0 = W'($urandom_range(15, 0));
      end else if (bus.req0 && m_owner == 0 && ($urandom_range(39, 0) == 0)) bus.req0 = 1'b0;
      else if ($urandom_range(7, 0) == 0) bus.len0 = W'($urandom_range(15, 0));

      if (e_done(1) && ($urandom_range(3, 0) != 0)) bus.req1 = 1'b0;
      else if (!bus.req1 && ($urandom_range(3, 0) == 0)) begin
        bus.req1 = 1'b1;
        bus.len1 = W'($urandom_range(15, 0));
      end else if (bus.req1 && m_owner == 1 && ($urandom_range(39, 0) == 0)) bus.req1 = 1'b0;
      else if ($urandom_range(7, 0) == 0) bus.len1 = W'($urandom_range(15, 0));

      reset = ($urandom_range(399, 0) == 0);
    end
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
